// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART (TX + RX) on the MEM-stage data bus.
// TXD at BASE_ADDR, RXD at BASE_ADDR+4, CON at BASE_ADDR+8; read data is combinational.
module uart_peripheral #(
  parameter int          BAUD_DIV  = 10417,
  parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_control_read,
  input  logic        i_control_write,
  input  logic [31:0] i_control_write_data,
  output logic [31:0] o_control_read_data,
  output logic        o_hit,
  output logic        o_irq,
  input  logic        i_uart_rx,
  output logic        o_uart_tx
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  logic hit_txd, hit_rxd, hit_con;
  logic wr_txd, wr_con, rd_rxd;
  logic unused_wdata;

  uart_state_t   tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_byte;
  logic          tx_tick, tx_load, tx_line, tx_busy;

  uart_state_t   rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_data;
  logic          rx_s1, rx_s2, rx_s3, rx_fall, rx_tick;
  logic          rx_stop_ok, rx_stop_bad;
  logic          rx_valid, rx_overrun, frame_err, rx_irq_en;

  assign hit_txd = (i_address == BASE_ADDR);
  assign hit_rxd = (i_address == BASE_ADDR + 32'd4);
  assign hit_con = (i_address == BASE_ADDR + 32'd8);
  assign o_hit   = hit_txd | hit_rxd | hit_con;
  assign wr_txd  = i_control_write & hit_txd;
  assign wr_con  = i_control_write & hit_con;
  assign rd_rxd  = i_control_read & hit_rxd;
  assign unused_wdata = ^i_control_write_data[31:8];

  assign tx_busy = (tx_state != IDLE);
  assign o_irq   = rx_irq_en & rx_valid;

  always_comb begin
    o_control_read_data = 32'd0;
    if (hit_txd) o_control_read_data = {24'd0, tx_byte};
    if (hit_rxd) o_control_read_data = {24'd0, rx_data};
    if (hit_con) o_control_read_data = {27'd0, rx_irq_en, frame_err, rx_overrun, rx_valid, tx_busy};
  end

  // A TXD write landing on the final stop-bit cycle chains straight into the next start bit.
  assign tx_tick = (tx_cnt == BIT_LAST);

  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    tx_line = 1'b1;
    case (tx_state)
      IDLE: if (wr_txd) begin
        tx_next = START;
        tx_load = 1'b1;
      end
      START: begin
        tx_line = 1'b0;
        if (tx_tick) tx_next = DATA;
      end
      DATA: begin
        tx_line = tx_byte[tx_bit];
        if (tx_tick && tx_bit == 3'd7) tx_next = STOP;
      end
      STOP: if (tx_tick) begin
        if (wr_txd) begin
          tx_next = START;
          tx_load = 1'b1;
        end else begin
          tx_next = IDLE;
        end
      end
      default: tx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tx_state <= IDLE;
    else        tx_state <= tx_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_cnt    <= '0;
      tx_bit    <= 3'd0;
      tx_byte   <= 8'd0;
      o_uart_tx <= 1'b1;
    end else begin
      if (tx_state == IDLE || tx_tick) tx_cnt <= '0;
      else                             tx_cnt <= tx_cnt + 1'b1;
      if (tx_state != DATA) tx_bit <= 3'd0;
      else if (tx_tick)     tx_bit <= tx_bit + 3'd1;
      if (tx_load) tx_byte <= i_control_write_data[7:0];
      o_uart_tx <= tx_line;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= i_uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // The start bit is sampled half a bit in, so every later sample lands mid-bit.
  assign rx_fall = rx_s3 & ~rx_s2;
  assign rx_tick = (rx_state == START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);

  always_comb begin
    rx_next     = rx_state;
    rx_stop_ok  = 1'b0;
    rx_stop_bad = 1'b0;
    case (rx_state)
      IDLE:  if (rx_fall) rx_next = START;
      START: if (rx_tick) rx_next = rx_s2 ? IDLE : DATA;
      DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = STOP;
      STOP:  if (rx_tick) begin
        rx_next     = IDLE;
        rx_stop_ok  = rx_s2;
        rx_stop_bad = ~rx_s2;
      end
      default: rx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_state <= IDLE;
    else        rx_state <= rx_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      if (rx_state == IDLE || rx_tick) rx_cnt <= '0;
      else                             rx_cnt <= rx_cnt + 1'b1;
      if (rx_state != DATA) rx_bit <= 3'd0;
      else if (rx_tick) begin
        rx_bit   <= rx_bit + 3'd1;
        rx_shift <= {rx_s2, rx_shift[7:1]};
      end
    end
  end

  // A byte completing on the same edge as an RXD read wins: valid stays set, no overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data    <= 8'd0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      rx_irq_en  <= 1'b0;
    end else begin
      if (rx_stop_ok) rx_data <= rx_shift;
      if (rx_stop_ok)  rx_valid <= 1'b1;
      else if (rd_rxd) rx_valid <= 1'b0;
      if (rx_stop_ok && rx_valid && !rd_rxd)       rx_overrun <= 1'b1;
      else if (wr_con && i_control_write_data[2]) rx_overrun <= 1'b0;
      if (rx_stop_bad)                             frame_err <= 1'b1;
      else if (wr_con && i_control_write_data[3]) frame_err <= 1'b0;
      if (wr_con) rx_irq_en <= i_control_write_data[4];
    end
  end

endmodule

// File: tb/tb_uart_peripheral.sv
// Directed bench for uart_peripheral at BAUD_DIV=4: TX framing, busy timing, RX flags, decode, reset.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_uart_peripheral;

  localparam logic [31:0] TXD  = 32'h40000018;
  localparam logic [31:0] RXD  = 32'h4000001C;
  localparam logic [31:0] CON  = 32'h40000020;
  localparam logic [31:0] MISS = 32'h40000024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        read_en;
  logic        write_en;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        hit;
  logic        irq;
  logic        uart_rx;
  logic        uart_tx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_peripheral #(.BAUD_DIV(4), .BASE_ADDR(32'h40000018)) dut (
    .clk                  (clk),
    .reset                (reset),
    .i_address            (address),
    .i_control_read       (read_en),
    .i_control_write      (write_en),
    .i_control_write_data (write_data),
    .o_control_read_data  (read_data),
    .o_hit                (hit),
    .o_irq                (irq),
    .i_uart_rx            (uart_rx),
    .o_uart_tx            (uart_tx)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic busIdle();
    address    = 32'd0;
    read_en    = 1'b0;
    write_en   = 1'b0;
    write_data = 32'd0;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    address    = addr;
    write_data = data;
    write_en   = 1'b1;
    read_en    = 1'b0;
    @(negedge clk);
    busIdle();
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data, output logic hit_seen);
    address  = addr;
    read_en  = 1'b1;
    write_en = 1'b0;
    #1;
    data     = read_data;
    hit_seen = hit;
    @(negedge clk);
    busIdle();
  endtask

  task automatic checkRead(input string tag, input logic [31:0] addr, input logic [31:0] expected);
    logic [31:0] d;
    logic        h;
    busRead(addr, d, h);
    checkOutput(tag, d, expected);
  endtask

  // Line level k falling edges after the accepting edge: 1, start x4, 8 data x4, stop.
  function automatic logic expTx(input logic [7:0] d, input int k);
    int b;
    if (k <= 1) return 1'b1;
    b = (k - 2) / 4;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  task automatic txStart(input logic [7:0] d);
    busWrite(TXD, {24'd0, d});
  endtask

  task automatic txFrame(input logic [7:0] d, input bit inject);
    for (int k = 1; k <= 40; k++) begin
      if (inject && (k == 9 || k == 40)) begin
        address = TXD; write_data = 32'h000000AA; write_en = 1'b1; read_en = 1'b0;
        #1;
        checkOutput("tx_line", {31'd0, uart_tx}, {31'd0, expTx(d, k)});
      end else if (inject && k == 12) begin
        address = TXD; write_en = 1'b0; read_en = 1'b1;
        #1;
        checkOutput("txd_hold", read_data, {24'd0, d});
        checkOutput("tx_line", {31'd0, uart_tx}, {31'd0, expTx(d, k)});
      end else begin
        address = CON; write_en = 1'b0; read_en = 1'b1;
        #1;
        checkOutput("tx_line", {31'd0, uart_tx}, {31'd0, expTx(d, k)});
        checkOutput("tx_busy", {31'd0, read_data[0]}, 32'd1);
      end
      @(negedge clk);
    end
    busIdle();
  endtask

  task automatic txIdleCheck();
    address = CON; read_en = 1'b1;
    #1;
    checkOutput("tx_idle_line", {31'd0, uart_tx}, 32'd1);
    checkOutput("tx_busy_clear", {31'd0, read_data[0]}, 32'd0);
    @(negedge clk);
    busIdle();
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (4) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    logic        h;
    busIdle();
    uart_rx = 1'b1;
    reset   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_tx", {31'd0, uart_tx}, 32'd1);
    checkOutput("reset_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkRead("reset_con", CON, 32'd0);
    checkRead("reset_rxd", RXD, 32'd0);

    $display("[TB] tx frame 0x55");
    txStart(8'h55);
    txFrame(8'h55, 1'b0);
    txIdleCheck();

    $display("[TB] tx drop mid-frame, chain on busy-clear edge");
    txStart(8'h55);
    txFrame(8'h55, 1'b1);
    txFrame(8'hAA, 1'b0);
    txIdleCheck();
    checkRead("txd_chained", TXD, 32'h000000AA);

    $display("[TB] rx 0xA5 with irq enabled");
    busWrite(CON, 32'h10);
    applyStimulus(8'hA5, 1'b1);
    checkOutput("irq_set", {31'd0, irq}, 32'd1);
    checkRead("con_valid", CON, 32'h12);
    checkRead("rxd_a5", RXD, 32'hA5);
    checkRead("con_after_read", CON, 32'h10);
    checkOutput("irq_clear", {31'd0, irq}, 32'd0);

    $display("[TB] rx overrun and framing error");
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    checkRead("con_overrun", CON, 32'h16);
    checkRead("rxd_22", RXD, 32'h22);
    busWrite(CON, 32'h04);
    checkRead("con_w1c_ovr", CON, 32'h00);
    applyStimulus(8'h33, 1'b0);
    checkRead("con_frame_err", CON, 32'h08);
    checkRead("rxd_kept", RXD, 32'h22);
    busWrite(CON, 32'h08);
    checkRead("con_w1c_ferr", CON, 32'h00);

    $display("[TB] rx glitch and decode");
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (10) @(negedge clk);
    checkRead("con_glitch", CON, 32'h00);
    applyStimulus(8'h5A, 1'b1);
    checkRead("con_after_glitch", CON, 32'h02);
    checkRead("rxd_5a", RXD, 32'h5A);
    busRead(MISS, d, h);
    checkOutput("miss_data", d, 32'd0);
    checkOutput("miss_hit", {31'd0, h}, 32'd0);
    busRead(TXD, d, h);
    checkOutput("txd_hit", {31'd0, h}, 32'd1);
    busWrite(MISS, 32'h1C);
    checkRead("con_miss_write", CON, 32'h00);

    $display("[TB] reset mid tx frame");
    txStart(8'h00);
    repeat (10) @(negedge clk);
    checkOutput("tx_mid_frame", {31'd0, uart_tx}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("tx_reset_async", {31'd0, uart_tx}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkRead("con_post_reset", CON, 32'h00);
    checkRead("rxd_post_reset", RXD, 32'h00);
    txStart(8'h3C);
    txFrame(8'h3C, 1'b0);
    txIdleCheck();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
